// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: widths, reset PC and FSM states.
package fetch_stage_pkg;

    localparam int          IWIDTH       = 32;
    localparam int          PC_WIDTH_DEF = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    // IDLE after reset, REQ while fetching, HOLD while the skid entry waits for
    // decode, DROP while an abandoned request is still outstanding.
    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_REQ  = 2'd1,
        FS_HOLD = 2'd2,
        FS_DROP = 2'd3
    } fs_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// One-entry skid buffer holding an {instr, pc} pair that decode could not take.
module fetch_buffer
    import fetch_stage_pkg::*;
#(
    parameter int PC_WIDTH = PC_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                unload,
    input  logic                clear,
    input  logic [IWIDTH-1:0]   fill_instr,
    input  logic [PC_WIDTH-1:0] fill_pc,
    output logic                valid,
    output logic [IWIDTH-1:0]   held_instr,
    output logic [PC_WIDTH-1:0] held_pc
);

    // Valid flag: clear (flush) wins over load, load wins over unload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (unload) begin
            valid <= 1'b0;
        end
    end

    // Payload is only meaningful while valid, so it carries no reset.
    always_ff @(posedge clk) begin
        if (load && !clear) begin
            held_instr <= fill_instr;
            held_pc    <= fill_pc;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, fetches over req/ack and feeds decode
// through a registered output backed by a one-entry skid buffer.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                  PC_WIDTH = PC_WIDTH_DEF,
    parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(RESET_PC_DEF)
) (
    input  logic                fs_clk,
    input  logic                fs_rst,
    input  logic                fs_i_stall,
    input  logic                fs_i_flush,
    input  logic [PC_WIDTH-1:0] fs_i_target,
    output logic                fs_o_imem_req,
    output logic [PC_WIDTH-1:0] fs_o_imem_addr,
    input  logic                fs_i_imem_ack,
    input  logic [IWIDTH-1:0]   fs_i_imem_data,
    output logic [IWIDTH-1:0]   fs_o_instr,
    output logic [PC_WIDTH-1:0] fs_o_pc,
    output logic [PC_WIDTH-1:0] fs_o_pc_plus4,
    output logic                fs_o_ce
);

    // Word-align a PC; the low two bits are forced to zero.
    function automatic logic [PC_WIDTH-1:0] pc_align(input logic [PC_WIDTH-1:0] pc);
        return pc & ~(PC_WIDTH'(3));
    endfunction

    // Sequential PC, wrapping modulo 2^PC_WIDTH.
    function automatic logic [PC_WIDTH-1:0] pc_next(input logic [PC_WIDTH-1:0] pc);
        return pc + PC_WIDTH'(4);
    endfunction

    fs_state_t             state, state_next;
    logic [PC_WIDTH-1:0]   fetch_pc;
    logic [PC_WIDTH-1:0]   drop_pc;

    logic                  out_free;
    logic                  out_clear;
    logic                  out_from_mem;
    logic                  out_from_skid;
    logic                  skid_load;
    logic                  skid_unload;
    logic                  skid_clear;
    logic                  pc_incr;
    logic                  pc_take_flush;
    logic                  pc_take_drop;
    logic                  drop_load;

    logic                  skid_valid;
    logic [IWIDTH-1:0]     skid_instr;
    logic [PC_WIDTH-1:0]   skid_pc;

    assign out_free       = !fs_o_ce || !fs_i_stall;
    assign fs_o_imem_req  = (state == FS_REQ) || (state == FS_DROP);
    assign fs_o_imem_addr = fetch_pc;
    assign fs_o_pc_plus4  = pc_next(fs_o_pc);

    fetch_buffer #(
        .PC_WIDTH (PC_WIDTH)
    ) u_skid (
        .clk        (fs_clk),
        .rst_n      (fs_rst),
        .load       (skid_load),
        .unload     (skid_unload),
        .clear      (skid_clear),
        .fill_instr (fs_i_imem_data),
        .fill_pc    (fetch_pc),
        .valid      (skid_valid),
        .held_instr (skid_instr),
        .held_pc    (skid_pc)
    );

    // State register.
    always_ff @(posedge fs_clk or negedge fs_rst) begin
        if (!fs_rst) begin
            state <= FS_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and datapath controls; flush outranks everything in every state.
    always_comb begin
        state_next    = state;
        out_clear     = 1'b0;
        out_from_mem  = 1'b0;
        out_from_skid = 1'b0;
        skid_load     = 1'b0;
        skid_unload   = 1'b0;
        skid_clear    = 1'b0;
        pc_incr       = 1'b0;
        pc_take_flush = 1'b0;
        pc_take_drop  = 1'b0;
        drop_load     = 1'b0;
        case (state)
            FS_IDLE: begin
                state_next = FS_REQ;
                if (fs_i_flush) begin
                    out_clear     = 1'b1;
                    skid_clear    = 1'b1;
                    pc_take_flush = 1'b1;
                end
            end
            FS_REQ: begin
                if (fs_i_flush) begin
                    out_clear  = 1'b1;
                    skid_clear = 1'b1;
                    if (fs_i_imem_ack) begin
                        pc_take_flush = 1'b1;
                    end else begin
                        drop_load  = 1'b1;
                        state_next = FS_DROP;
                    end
                end else if (fs_i_imem_ack) begin
                    pc_incr = 1'b1;
                    if (out_free) begin
                        out_from_mem = 1'b1;
                    end else begin
                        skid_load  = 1'b1;
                        state_next = FS_HOLD;
                    end
                end else if (!fs_i_stall) begin
                    out_clear = 1'b1;
                end
            end
            FS_HOLD: begin
                if (fs_i_flush) begin
                    out_clear     = 1'b1;
                    skid_clear    = 1'b1;
                    pc_take_flush = 1'b1;
                    state_next    = FS_REQ;
                end else if (!fs_i_stall) begin
                    out_from_skid = skid_valid;
                    skid_unload   = 1'b1;
                    state_next    = FS_REQ;
                end
            end
            FS_DROP: begin
                if (fs_i_flush) begin
                    out_clear  = 1'b1;
                    skid_clear = 1'b1;
                    if (fs_i_imem_ack) begin
                        pc_take_flush = 1'b1;
                        state_next    = FS_REQ;
                    end else begin
                        drop_load = 1'b1;
                    end
                end else if (fs_i_imem_ack) begin
                    pc_take_drop = 1'b1;
                    state_next   = FS_REQ;
                end
            end
            default: state_next = FS_IDLE;
        endcase
    end

    // Fetch PC and the redirect target parked while an abandoned request drains.
    always_ff @(posedge fs_clk or negedge fs_rst) begin
        if (!fs_rst) begin
            fetch_pc <= RESET_PC;
            drop_pc  <= RESET_PC;
        end else begin
            if (pc_take_flush) begin
                fetch_pc <= pc_align(fs_i_target);
            end else if (pc_take_drop) begin
                fetch_pc <= drop_pc;
            end else if (pc_incr) begin
                fetch_pc <= pc_next(fetch_pc);
            end
            if (drop_load) begin
                drop_pc <= pc_align(fs_i_target);
            end
        end
    end

    // Registered decode-facing outputs.
    always_ff @(posedge fs_clk or negedge fs_rst) begin
        if (!fs_rst) begin
            fs_o_ce    <= 1'b0;
            fs_o_instr <= '0;
            fs_o_pc    <= '0;
        end else if (out_clear) begin
            fs_o_ce <= 1'b0;
        end else if (out_from_mem) begin
            fs_o_ce    <= 1'b1;
            fs_o_instr <= fs_i_imem_data;
            fs_o_pc    <= fetch_pc;
        end else if (out_from_skid) begin
            fs_o_ce    <= 1'b1;
            fs_o_instr <= skid_instr;
            fs_o_pc    <= skid_pc;
        end
    end

endmodule
